sub_bytes_iter: RTL
===================

Name: sub_bytes_iter

Overview:
Iterative forward AES SubBytes engine for the encryption datapath. It is the encrypt-side counterpart of the decrypt-side inverse substitution.
- Captures a 128-bit state and substitutes BYTES_PER_CYCLE bytes per clock through forward S-box lookup instances.
- Presents the substituted state behind a valid/ready output handshake.
- Trades latency for area: 4 S-boxes instead of 16 at the default setting.

Parameters:
BYTES_PER_CYCLE, 4, S-box instances and bytes substituted per RUN cycle; legal values 1, 2, 4, 8, 16; NCHUNK = 16/BYTES_PER_CYCLE.

Ports:
i_clk  input  1  clock; all state changes on the rising edge
i_rst  input  1  reset, synchronous and active-high
i_valid  input  1  upstream has a state on i_state
o_ready  output  1  block can accept a state (high only in IDLE)
i_state  input  128  state to substitute; byte 0 = [127:120], byte 15 = [7:0]
o_valid  output  1  o_state holds a completed result
i_ready  input  1  downstream accepts the result
o_state  output  128  substituted state, same byte ordering as i_state
o_busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (i_rst=1 at a rising edge): FSM=IDLE, chunk counter=0, working register=0. Outputs: o_ready=1, o_valid=0, o_busy=0, o_state=128'h0.
- Reset has priority over every other event, including mid-RUN and mid-DONE. Any in-flight block is discarded and no o_valid is produced for it.
- FSM states are IDLE, RUN and DONE.
- IDLE: o_ready=1.
  - On an edge with i_valid=1, capture i_state into the input register, clear the counter and go to RUN.
  - With i_valid=0, stay in IDLE.
- RUN: o_ready=0, o_busy=1.
  - Each edge writes S(byte) for bytes [cnt*B .. cnt*B+B-1] into the same byte positions of the working register, where B=BYTES_PER_CYCLE. Byte 0 is processed first. cnt then increments.
  - Bytes not yet processed in the working register are don't-care.
  - On the edge that writes chunk NCHUNK-1, go to DONE and set o_valid=1.
  - i_state and i_valid are ignored in RUN; the captured copy is used.
- Latency: o_valid is first high in the cycle after the NCHUNK-th rising edge following the accepting edge. That is 4 cycles at the default and 1 cycle at B=16.
- DONE: o_valid=1, o_ready=0.
  - o_state must stay stable while i_valid/i_ready are not both satisfied, i.e. while o_valid=1 and i_ready=0.
  - On an edge with i_ready=1, o_valid drops and the FSM goes to IDLE.
  - A new block cannot be accepted on the same edge.
- Minimum issue interval: NCHUNK+2 cycles per block.
- o_state is checked only while o_valid=1; at other times its value is don't-care.
- Counter width is clog2(NCHUNK), minimum 1 bit. The counter never wraps inside a block because the exit happens at NCHUNK-1.
- i_ready asserted in IDLE or RUN has no effect.
- i_valid held high continuously: one block is accepted per IDLE visit and none are lost or duplicated.

Test Plan:
- Reset then i_state=128'h193de3bea0f4e22b9ac68d2ae9f84808 with i_valid=1, i_ready=1 -> o_valid high exactly 4 cycles after the accepting edge with o_state=128'hd42711aee0bf98f1b8b45de51e415230, then o_valid drops for one cycle.
- i_state=128'h0 -> o_state=128'h63636363636363636363636363636363; i_state=all 8'hFF -> all 8'h16; i_state with every byte 8'h53 -> every byte 8'hED.
- Backpressure: hold i_ready=0 for 10 cycles in DONE and change i_state/i_valid freely -> o_valid stays 1, o_state stays unchanged, o_ready stays 0; raising i_ready releases the block and returns to IDLE next cycle.
- Reset asserted during RUN (cnt=2) -> next cycle o_valid=0, o_busy=0, o_ready=1, o_state=0; a subsequent block with i_state=128'h01 in the lowest byte (others 0) yields 8'h7C in [7:0] and 8'h63 elsewhere.
- Back-to-back with i_valid=1 held and i_ready=1 held, with 3 distinct blocks -> 3 results in order, each matching the reference S-box model, with o_valid pulses spaced 6 cycles apart.
- Regression for BYTES_PER_CYCLE=1 and 16 on the first vector -> latency 16 and 1 cycle respectively, with identical o_state.

Source files
------------

// File: rtl/sub_bytes_iter.sv
// Iterative forward AES SubBytes: captures a 128-bit state and substitutes
// BYTES_PER_CYCLE bytes per clock, then holds the result behind valid/ready.
module sub_bytes_iter #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [127:0] i_state,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_state,
  output logic         o_busy,
  output logic [1:0]   o_dbg_state
);

  localparam int NCHUNK = 16 / BYTES_PER_CYCLE;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    sbox = SBOX_TABLE[2047 - 8 * int'(x) -: 8];
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [127:0]    in_q;
  logic [127:0]    work_q, work_d;
  logic            last_chunk;

  assign last_chunk = (cnt_q == LAST_CNT);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; upstream uses i_valid/o_ready, downstream o_valid/i_ready, and
  // the producer holds its data stable until that edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid) state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Substitute the current chunk; every other byte keeps its old value.
  always_comb begin
    work_d = work_q;
    for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
      work_d[127 - 8 * (int'(cnt_q) * BYTES_PER_CYCLE + k) -: 8] =
        sbox(in_q[127 - 8 * (int'(cnt_q) * BYTES_PER_CYCLE + k) -: 8]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      in_q    <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            in_q  <= i_state;
            cnt_q <= '0;
          end
        end
        RUN: begin
          work_q <= work_d;
          // Hold on the final chunk so a single-chunk counter never wraps.
          if (!last_chunk) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_ready     = (state_q == IDLE);
  assign o_valid     = (state_q == DONE);
  assign o_busy      = (state_q != IDLE);
  assign o_state     = work_q;
  assign o_dbg_state = state_q;

endmodule
